// File: rtl/poly_arpeggiator.sv
// poly_arpeggiator: steps through the currently held keys one at a time, producing a
// one-hot note-on vector with programmable step and gate lengths.
//
// Ports
//   CLK         system clock, all state on the rising edge
//   RESET       asynchronous active-high reset
//   Enable      1 = arpeggiate, 0 = bypass (key_on follows keys one clock late)
//   keys        held-key vector, bit 0 is the lowest note
//   mode        00 up, 01 down, 10 up-down, 11 up with latch/hold
//   step_len    clocks per step (0 behaves as 1)
//   gate_len    clocks the note sounds within a step (>= step_len gives legato)
//   key_on      registered note-on vector
//   cur_idx     index of the current step key
//   step_pulse  one-clock pulse at each step start
module poly_arpeggiator #(
    parameter int unsigned NUM_KEYS = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        Enable,
    input  logic [NUM_KEYS-1:0]         keys,
    input  logic [1:0]                  mode,
    input  logic [CNT_W-1:0]            step_len,
    input  logic [CNT_W-1:0]            gate_len,
    output logic [NUM_KEYS-1:0]         key_on,
    output logic [$clog2(NUM_KEYS)-1:0] cur_idx,
    output logic                        step_pulse
);

    localparam int unsigned IDX_W = $clog2(NUM_KEYS);

    typedef enum logic [1:0] {
        StBypass = 2'd0,
        StWait   = 2'd1,
        StPlay   = 2'd2
    } state_e;

    state_e              st_q, st_d;
    logic [CNT_W-1:0]    timer_q, timer_d;
    logic [IDX_W-1:0]    cur_q, cur_d;
    logic                dir_q, dir_d;       // 0 = up, 1 = down (mode 10 only)
    logic [NUM_KEYS-1:0] latch_q, latch_d;
    logic                released_q, released_d;
    logic [NUM_KEYS-1:0] key_on_q, key_on_d;
    logic                pulse_q, pulse_d;

    logic [NUM_KEYS-1:0] avail;
    logic [CNT_W-1:0]    step_max;
    logic                terminal;
    logic                cur_gone;
    logic [IDX_W:0]      fwd_hit, back_hit, wrap_hit;
    logic [IDX_W-1:0]    adv_idx;
    logic                adv_dir;

    // Nearest available key from cur (excluded) in the given direction. Returns {found, idx};
    // idx falls back to cur when nothing is found.
    function automatic logic [IDX_W:0] scan(input logic [NUM_KEYS-1:0] av,
                                            input logic [IDX_W-1:0]    cur,
                                            input logic                down,
                                            input logic                wrap);
        logic             found;
        logic [IDX_W-1:0] res;
        int               j;
        found = 1'b0;
        res   = cur;
        for (int i = 1; i < int'(NUM_KEYS); i++) begin
            j = down ? int'(cur) - i : int'(cur) + i;
            if (wrap) begin
                if (j < 0) begin
                    j = j + int'(NUM_KEYS);
                end else if (j >= int'(NUM_KEYS)) begin
                    j = j - int'(NUM_KEYS);
                end
            end
            if (!found && j >= 0 && j < int'(NUM_KEYS)) begin
                if (av[IDX_W'(j)]) begin
                    found = 1'b1;
                    res   = IDX_W'(j);
                end
            end
        end
        return {found, res};
    endfunction

    // Lowest (down=0) or highest (down=1) set bit.
    function automatic logic [IDX_W-1:0] first_key(input logic [NUM_KEYS-1:0] av,
                                                   input logic                down);
        logic             found;
        logic [IDX_W-1:0] res;
        int               k;
        found = 1'b0;
        res   = '0;
        for (int i = 0; i < int'(NUM_KEYS); i++) begin
            k = down ? int'(NUM_KEYS) - 1 - i : i;
            if (!found && av[IDX_W'(k)]) begin
                found = 1'b1;
                res   = IDX_W'(k);
            end
        end
        return res;
    endfunction

    // Hold latch: outside mode 11 it tracks keys so entering hold starts from what is held.
    always_comb begin
        latch_d    = latch_q;
        released_d = (keys == '0);
        if (mode != 2'b11) begin
            latch_d = keys;
        end else if (keys != '0) begin
            latch_d = released_q ? keys : (latch_q | keys);
        end
    end

    always_comb begin
        avail    = (mode == 2'b11) ? latch_q : keys;
        step_max = (step_len == '0) ? '0 : step_len - CNT_W'(1);
        terminal = (timer_q >= step_max);
        cur_gone = !avail[cur_q];

        fwd_hit  = scan(avail, cur_q, dir_q, 1'b0);
        back_hit = scan(avail, cur_q, !dir_q, 1'b0);
        wrap_hit = scan(avail, cur_q, (mode == 2'b01), 1'b1);

        adv_idx = cur_q;
        adv_dir = dir_q;
        if (mode == 2'b10) begin
            if (fwd_hit[IDX_W]) begin
                adv_idx = fwd_hit[IDX_W-1:0];
            end else if (back_hit[IDX_W]) begin
                adv_idx = back_hit[IDX_W-1:0];
                adv_dir = !dir_q;
            end
        end else if (wrap_hit[IDX_W]) begin
            adv_idx = wrap_hit[IDX_W-1:0];
        end
    end

    always_comb begin
        st_d     = st_q;
        timer_d  = timer_q;
        cur_d    = cur_q;
        dir_d    = dir_q;
        pulse_d  = 1'b0;
        key_on_d = '0;

        if (!Enable) begin
            st_d     = StBypass;
            timer_d  = '0;
            key_on_d = keys;
        end else begin
            unique case (st_q)
                StBypass: begin
                    st_d    = StWait;
                    timer_d = '0;
                end
                StWait: begin
                    if (avail != '0) begin
                        st_d    = StPlay;
                        cur_d   = first_key(avail, (mode == 2'b01));
                        timer_d = '0;
                        pulse_d = 1'b1;
                    end
                end
                StPlay: begin
                    if (avail == '0) begin
                        st_d    = StWait;
                        timer_d = '0;
                    end else if (terminal || cur_gone) begin
                        // A release on the terminal clock folds into this one advance.
                        cur_d   = adv_idx;
                        dir_d   = adv_dir;
                        timer_d = '0;
                        pulse_d = 1'b1;
                    end else begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                end
                default: begin
                    st_d    = StBypass;
                    timer_d = '0;
                end
            endcase
            if (st_d == StPlay && timer_d < gate_len && avail[cur_d]) begin
                key_on_d[cur_d] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            st_q       <= StBypass;
            timer_q    <= '0;
            cur_q      <= '0;
            dir_q      <= 1'b0;
            latch_q    <= '0;
            released_q <= 1'b1;
            key_on_q   <= '0;
            pulse_q    <= 1'b0;
        end else begin
            st_q       <= st_d;
            timer_q    <= timer_d;
            cur_q      <= cur_d;
            dir_q      <= dir_d;
            latch_q    <= latch_d;
            released_q <= released_d;
            key_on_q   <= key_on_d;
            pulse_q    <= pulse_d;
        end
    end

    assign key_on     = key_on_q;
    assign cur_idx    = cur_q;
    assign step_pulse = pulse_q;

endmodule

// File: tb/tb_poly_arpeggiator.sv
module tb_poly_arpeggiator;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        Enable = 1'b0;
    logic [7:0]  keys = '0;
    logic [1:0]  mode = '0;
    logic [15:0] step_len = '0;
    logic [15:0] gate_len = '0;
    logic [7:0]  key_on;
    logic [2:0]  cur_idx;
    logic        step_pulse;

    int errors = 0;
    int checks = 0;

    poly_arpeggiator #(.NUM_KEYS(8), .CNT_W(16)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .Enable     (Enable),
        .keys       (keys),
        .mode       (mode),
        .step_len   (step_len),
        .gate_len   (gate_len),
        .key_on     (key_on),
        .cur_idx    (cur_idx),
        .step_pulse (step_pulse)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        en;
        logic [7:0]  k;
        logic [1:0]  m;
        logic [15:0] s;
        logic [15:0] g;
        logic [7:0]  exp_on;
        logic [2:0]  exp_idx;
        logic        exp_pulse;
    } vec_t;

    vec_t tbl[$];
    logic [2:0] seq10[5];
    logic [2:0] seq01[3];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [7:0] on, input logic [2:0] idx,
                           input logic p);
        chk({name, ".key_on"}, int'(key_on), int'(on));
        chk({name, ".cur_idx"}, int'(cur_idx), int'(idx));
        chk({name, ".pulse"}, int'(step_pulse), int'(p));
    endtask

    // Bypass for one clock with keys released, then enable; returns in the first PLAY clock.
    task automatic restart(input logic [1:0] m, input logic [7:0] k, input logic [15:0] s,
                           input logic [15:0] g);
        Enable = 1'b0; keys = '0; mode = m; step_len = s; gate_len = g;
        tick();
        Enable = 1'b1; keys = k;
        tick();
        tick();
    endtask

    initial begin
        // bypass
        tbl.push_back('{1'b0, 8'h5A, 2'd0, 16'd4, 16'd2, 8'h5A, 3'd0, 1'b0});
        tbl.push_back('{1'b0, 8'h33, 2'd0, 16'd4, 16'd2, 8'h33, 3'd0, 1'b0});
        // mode 00, keys 0,2,5, step 4 gate 2
        tbl.push_back('{1'b1, 8'h25, 2'd0, 16'd4, 16'd2, 8'h00, 3'd0, 1'b0});
        tbl.push_back('{1'b1, 8'h25, 2'd0, 16'd4, 16'd2, 8'h01, 3'd0, 1'b1});
        tbl.push_back('{1'b1, 8'h25, 2'd0, 16'd4, 16'd2, 8'h01, 3'd0, 1'b0});
        tbl.push_back('{1'b1, 8'h25, 2'd0, 16'd4, 16'd2, 8'h00, 3'd0, 1'b0});
        tbl.push_back('{1'b1, 8'h25, 2'd0, 16'd4, 16'd2, 8'h00, 3'd0, 1'b0});
        tbl.push_back('{1'b1, 8'h25, 2'd0, 16'd4, 16'd2, 8'h04, 3'd2, 1'b1});
        tbl.push_back('{1'b1, 8'h25, 2'd0, 16'd4, 16'd2, 8'h04, 3'd2, 1'b0});
        tbl.push_back('{1'b1, 8'h25, 2'd0, 16'd4, 16'd2, 8'h00, 3'd2, 1'b0});
        tbl.push_back('{1'b1, 8'h25, 2'd0, 16'd4, 16'd2, 8'h00, 3'd2, 1'b0});
        tbl.push_back('{1'b1, 8'h25, 2'd0, 16'd4, 16'd2, 8'h20, 3'd5, 1'b1});
        tbl.push_back('{1'b1, 8'h25, 2'd0, 16'd4, 16'd2, 8'h20, 3'd5, 1'b0});
        tbl.push_back('{1'b1, 8'h25, 2'd0, 16'd4, 16'd2, 8'h00, 3'd5, 1'b0});
        tbl.push_back('{1'b1, 8'h25, 2'd0, 16'd4, 16'd2, 8'h00, 3'd5, 1'b0});
        tbl.push_back('{1'b1, 8'h25, 2'd0, 16'd4, 16'd2, 8'h01, 3'd0, 1'b1});
        tbl.push_back('{1'b1, 8'h25, 2'd0, 16'd4, 16'd2, 8'h01, 3'd0, 1'b0});
        seq10[0] = 3'd3; seq10[1] = 3'd6; seq10[2] = 3'd3; seq10[3] = 3'd1; seq10[4] = 3'd3;
        seq01[0] = 3'd3; seq01[1] = 3'd1; seq01[2] = 3'd6;

        // reset is asynchronous: outputs clear before any clock edge
        #1 RESET = 1'b1;
        #1;
        chk_all("reset", 8'h00, 3'd0, 1'b0);
        tick();
        tick();
        #2 RESET = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            Enable = tbl[i].en; keys = tbl[i].k; mode = tbl[i].m;
            step_len = tbl[i].s; gate_len = tbl[i].g;
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].exp_on, tbl[i].exp_idx, tbl[i].exp_pulse);
        end

        // mode 10 ping-pong over keys 1,3,6
        restart(2'd2, 8'h4A, 16'd1, 16'd1);
        chk_all("m10.first", 8'h02, 3'd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("m10.step%0d", i), int'(cur_idx), int'(seq10[i]));
        end

        // mode 01 descending with wrap
        restart(2'd1, 8'h4A, 16'd1, 16'd1);
        chk_all("m01.first", 8'h40, 3'd6, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("m01.step%0d", i), int'(cur_idx), int'(seq01[i]));
        end

        // drop the current key mid-step, then drop everything
        restart(2'd0, 8'h11, 16'd4, 16'd4);
        chk_all("drop.first", 8'h01, 3'd0, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        chk_all("drop.k4", 8'h10, 3'd4, 1'b1);
        tick();
        keys = 8'h01;
        tick();
        chk_all("drop.adv", 8'h01, 3'd0, 1'b1);
        keys = 8'h00;
        tick();
        chk_all("drop.wait", 8'h00, 3'd0, 1'b0);

        // release of current key on its terminal clock gives one advance
        restart(2'd0, 8'h11, 16'd2, 16'd2);
        tick();
        tick();
        tick();
        chk("term.cur4", int'(cur_idx), 4);
        keys = 8'h01;
        tick();
        chk_all("term.adv", 8'h01, 3'd0, 1'b1);
        tick();
        chk_all("term.hold", 8'h01, 3'd0, 1'b0);

        // mode 11 hold
        restart(2'd3, 8'h24, 16'd1, 16'd1);
        chk_all("hold.first", 8'h04, 3'd2, 1'b1);
        keys = 8'h00;
        tick();
        chk_all("hold.s1", 8'h20, 3'd5, 1'b1);
        tick();
        chk_all("hold.s2", 8'h04, 3'd2, 1'b1);
        keys = 8'h80;
        tick();
        chk("hold.s3", int'(cur_idx), 5);
        tick();
        chk_all("hold.new", 8'h80, 3'd7, 1'b1);
        keys = 8'h00;
        tick();
        chk_all("hold.single", 8'h80, 3'd7, 1'b1);

        // async reset mid-step
        restart(2'd0, 8'h25, 16'd1, 16'd1);
        tick();
        chk("rst.pre", int'(cur_idx), 2);
        #3 RESET = 1'b1;
        #1;
        chk_all("rst.async", 8'h00, 3'd0, 1'b0);
        tick();
        chk_all("rst.held", 8'h00, 3'd0, 1'b0);
        #3 RESET = 1'b0;

        // step_len 0 behaves as 1
        Enable = 1'b1; keys = 8'h25; mode = 2'd0; step_len = 16'd0; gate_len = 16'd1;
        tick();
        chk_all("s0.wait", 8'h00, 3'd0, 1'b0);
        tick();
        chk_all("s0.a", 8'h01, 3'd0, 1'b1);
        tick();
        chk_all("s0.b", 8'h04, 3'd2, 1'b1);
        tick();
        chk_all("s0.c", 8'h20, 3'd5, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
